// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Shadow records carry addresses at a fixed width; REG_ADDR_W must not exceed this.
  localparam int REC_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REC_ADDR_W-1:0] rd;
    logic                  reg_wrenable;
    logic                  mem_to_reg;
    logic                  halt;
    logic [REC_ADDR_W-1:0] rs1;
    logic [REC_ADDR_W-1:0] rs2;
  } shadow_t;

  function automatic logic writes_reg(input shadow_t r, input logic [REC_ADDR_W-1:0] a);
    return r.valid && r.reg_wrenable && (r.rd != '0) && (r.rd == a);
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with halt drain FSM
// HAZARD_FWD_EN: enables EX operand forwarding; otherwise interlock on every in-flight writer.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_wrenable,
  input  logic                  id_mem_to_reg,
  input  logic                  id_halt,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_jump_taken,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  shadow_t          r_ex, r_mem, r_wb, w_id_rec;
  logic             w_stall, w_use1, w_use2, w_unused;
  logic [1:0]       w_fwd_a, w_fwd_b;

  always_comb begin
    w_id_rec              = '0;
    w_id_rec.valid        = id_valid;
    w_id_rec.rd           = REC_ADDR_W'(id_rd);
    w_id_rec.reg_wrenable = id_reg_wrenable;
    w_id_rec.mem_to_reg   = id_mem_to_reg;
    w_id_rec.halt         = id_halt;
    w_id_rec.rs1          = REC_ADDR_W'(id_rs1);
    w_id_rec.rs2          = REC_ADDR_W'(id_rs2);
  end

  assign w_use1 = id_valid && id_uses_rs1;
  assign w_use2 = id_valid && id_uses_rs2;

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign w_stall = r_ex.valid && r_ex.mem_to_reg && (r_ex.rd != '0) &&
                   ((w_use1 && (r_ex.rd == w_id_rec.rs1)) ||
                    (w_use2 && (r_ex.rd == w_id_rec.rs2)));
  assign w_fwd_a = writes_reg(r_mem, r_ex.rs1) ? FWD_MEM :
                   writes_reg(r_wb,  r_ex.rs1) ? FWD_WB  : FWD_RF;
  assign w_fwd_b = writes_reg(r_mem, r_ex.rs2) ? FWD_MEM :
                   writes_reg(r_wb,  r_ex.rs2) ? FWD_WB  : FWD_RF;
`else
  assign w_stall = (w_use1 && (writes_reg(r_ex, w_id_rec.rs1) || writes_reg(r_mem, w_id_rec.rs1) ||
                               writes_reg(r_wb, w_id_rec.rs1))) ||
                   (w_use2 && (writes_reg(r_ex, w_id_rec.rs2) || writes_reg(r_mem, w_id_rec.rs2) ||
                               writes_reg(r_wb, w_id_rec.rs2)));
  assign w_fwd_a = FWD_RF;
  assign w_fwd_b = FWD_RF;
`endif

  assign w_unused = ^{r_ex.halt, r_ex.mem_to_reg, r_ex.rs1, r_ex.rs2,
                      r_mem.mem_to_reg, r_mem.halt, r_mem.rs1, r_mem.rs2,
                      r_wb.mem_to_reg, r_wb.halt, r_wb.rs1, r_wb.rs2, FWD_MEM, FWD_WB};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    fwd_a       = w_fwd_a;
    fwd_b       = w_fwd_b;
    case (r_state)
      ST_RUN: begin
        if (ex_jump_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_stall) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end else if (id_valid && id_halt) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_HALTED;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_HALTED: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        halted     = 1'b1;
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    // Reset must look like a clean RUN cycle regardless of what ID/EX present.
    if (rst) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ex    <= idex_flush ? '0 : w_id_rec;
      r_mem   <= r_ex;
      r_wb    <= r_mem;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk, rst;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_wrenable, id_mem_to_reg, id_halt;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_jump_taken;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, halted;
  logic [1:0] fwd_a, fwd_b;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_we, ifid_we, ifid_flush, idex_flush}
  localparam logic [3:0] C_RUN  = 4'b1100;
  localparam logic [3:0] C_HOLD = 4'b0001;
  localparam logic [3:0] C_JUMP = 4'b1111;

  hazard_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_wrenable(id_reg_wrenable), .id_mem_to_reg(id_mem_to_reg), .id_halt(id_halt),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_jump_taken(ex_jump_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic id_set(input logic v, input logic u1, input logic [4:0] s1,
                        input logic u2, input logic [4:0] s2, input logic [4:0] d,
                        input logic we, input logic mtr, input logic hlt);
    id_valid = v; id_uses_rs1 = u1; id_rs1 = s1; id_uses_rs2 = u2; id_rs2 = s2;
    id_rd = d; id_reg_wrenable = we; id_mem_to_reg = mtr; id_halt = hlt;
  endtask

  task automatic id_idle();
    id_set(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [3:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic h);
    logic [8:0] obs, exp;
    exp = {ctl, fa, fb, h};
    obs = {pc_we, ifid_we, ifid_flush, idex_flush, fwd_a, fwd_b, halted};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic h);
    #4;
    chk(tag, ctl, fa, fb, h);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    id_idle();
    ex_jump_taken = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    ex_jump_taken = 1'b1;
    id_idle();
    #4;
    chk("reset_ignores_jump", C_RUN, 2'b00, 2'b00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ex_jump_taken = 1'b0;
    rst = 1'b0;
    step("after_reset", C_RUN, 2'b00, 2'b00, 1'b0);

    // load x5 ; add x6,x5,x1
    id_set(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1, 0);
    step("a_load_id", C_RUN, 2'b00, 2'b00, 1'b0);
    id_set(1, 1, 5'd5, 1, 5'd1, 5'd6, 1, 0, 0);
    step("a_loaduse_stall", C_HOLD, 2'b00, 2'b00, 1'b0);
`ifdef HAZARD_FWD_EN
    step("a_stall_released", C_RUN, 2'b00, 2'b00, 1'b0);
    id_idle();
    step("a_add_fwd_wb", C_RUN, 2'b10, 2'b00, 1'b0);
`else
    step("a_stall_mem", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("a_stall_wb", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("a_add_issue", C_RUN, 2'b00, 2'b00, 1'b0);
`endif
    idle(3);

    // add x3,x1,x2 ; sub x4,x3,x3
    id_set(1, 1, 5'd1, 1, 5'd2, 5'd3, 1, 0, 0);
    step("b_add_id", C_RUN, 2'b00, 2'b00, 1'b0);
    id_set(1, 1, 5'd3, 1, 5'd3, 5'd4, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    step("b_sub_no_stall", C_RUN, 2'b00, 2'b00, 1'b0);
    id_idle();
    step("b_sub_fwd_mem", C_RUN, 2'b01, 2'b01, 1'b0);
`else
    step("b_stall_ex", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("b_stall_mem", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("b_stall_wb", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("b_sub_issue", C_RUN, 2'b00, 2'b00, 1'b0);
    id_idle();
    step("b_sub_ex_nofwd", C_RUN, 2'b00, 2'b00, 1'b0);
`endif
    idle(3);

    // jump coincident with load-use
    id_set(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1, 0);
    step("c_load_id", C_RUN, 2'b00, 2'b00, 1'b0);
    id_set(1, 1, 5'd5, 1, 5'd1, 5'd6, 1, 0, 0);
    ex_jump_taken = 1'b1;
    step("c_jump_over_stall", C_JUMP, 2'b00, 2'b00, 1'b0);
    idle(3);

    // writer of x0 then reader of x0
    id_set(1, 0, 5'd0, 0, 5'd0, 5'd0, 1, 0, 0);
    step("d_x0_writer", C_RUN, 2'b00, 2'b00, 1'b0);
    id_set(1, 1, 5'd0, 1, 5'd0, 5'd7, 1, 0, 0);
    step("d_x0_no_stall", C_RUN, 2'b00, 2'b00, 1'b0);
    id_idle();
    step("d_x0_no_fwd", C_RUN, 2'b00, 2'b00, 1'b0);
    idle(3);

    // halt flushed by a jump never drains
    id_set(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1);
    ex_jump_taken = 1'b1;
    step("e_halt_jumped", C_JUMP, 2'b00, 2'b00, 1'b0);
    ex_jump_taken = 1'b0;
    id_idle();
    step("e_stays_run", C_RUN, 2'b00, 2'b00, 1'b0);
    idle(3);
    step("e_not_halted", C_RUN, 2'b00, 2'b00, 1'b0);

    // halt drains for three cycles, then sticks
    id_set(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1);
    step("f_halt_id", C_RUN, 2'b00, 2'b00, 1'b0);
    id_idle();
    step("f_drain1", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("f_drain2", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("f_drain3", C_HOLD, 2'b00, 2'b00, 1'b0);
    step("f_halted", C_HOLD, 2'b00, 2'b00, 1'b1);
    id_set(1, 1, 5'd1, 0, 5'd0, 5'd2, 1, 0, 0);
    step("f_sticky", C_HOLD, 2'b00, 2'b00, 1'b1);

    // reset out of HALTED, then reset mid-drain
    id_idle();
    rst = 1'b1;
    step("g_reset_from_halted", C_RUN, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    id_set(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1);
    step("g_halt_id", C_RUN, 2'b00, 2'b00, 1'b0);
    id_idle();
    step("g_drain", C_HOLD, 2'b00, 2'b00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("g_rst_mid_drain", C_RUN, 2'b00, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    step("g_no_halt_after_rst", C_RUN, 2'b00, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
